alu_op_sequencer: RTL

- Command-driven controller that sequences the shared ALU_A1 datapath (RA/RB operands, add/sub select `s`, result, carry_out, zero_flag).
- Accepts one operation at a time over a valid/ready command port and drives registered operands into the ALU.
- After one settle cycle it captures the ALU result and flags, then returns them over a valid/ready response port.
- Keeps sticky status flags and a completed-operation counter for the rest of the 8-bit machine.

---
 rtl/alu_op_sequencer_if.sv | 30 +++
 rtl/alu_op_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command/response link between the operation sequencer and its requester.
// The requester (master) issues one ALU operation at a time and collects the
// captured result; the sequencer (slave) owns the ready/valid returns.
interface alu_op_sequencer_if #(
  parameter int BITS = 8
);
  // Command channel
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [BITS-1:0] cmd_a;
  logic [BITS-1:0] cmd_b;

  // Response channel
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_data;
  logic            rsp_carry;
  logic            rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer for the shared ALU_A1 datapath.
// Accepts one command, presents registered operands to the ALU, waits one
// settle cycle, captures result and flags, then hands them back over the
// response channel. CMP updates only the sticky flags and the op counter.
module alu_op_sequencer #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [BITS:0]   alu_ra,
  output logic [BITS:0]   alu_rb,
  output logic            alu_s,
  input  logic [BITS:0]   alu_out,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic            flag_c,
  output logic            flag_z,
  output logic            busy,
  output logic [7:0]      op_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [1:0]      op_reg;

  logic [BITS:0]   ra_reg;
  logic [BITS:0]   rb_reg;
  logic            s_reg;
  logic [BITS:0]   ra_next;
  logic [BITS:0]   rb_next;
  logic            s_next;

  logic [BITS-1:0] rsp_data_reg;
  logic            rsp_carry_reg;
  logic            rsp_zero_reg;
  logic            flag_c_reg;
  logic            flag_z_reg;
  logic [7:0]      op_count_reg;

  logic            accept;
  logic            capture;
  logic            cmd_ready_int;
  logic            rsp_valid_int;
  logic            busy_int;

  // Carry is reported through alu_carry, so the ALU's top result bit is not
  // needed here; keep it visibly consumed.
  logic            unused_alu_msb;
  assign unused_alu_msb = alu_out[BITS];

  // A new command may land while idle, or on the same edge that retires a
  // pending response. Held low while reset is asserted.
  assign cmd_ready_int = rst_n &&
                         ((state_reg == ST_IDLE) ||
                          ((state_reg == ST_RESP) && bus.rsp_ready));
  assign accept        = bus.cmd_valid && cmd_ready_int;

  // Operand formation for the ALU: zero-extend A/B, INC substitutes 1 for B,
  // subtract-type ops select the ALU's subtract path.
  always_comb begin
    ra_next = {1'b0, bus.cmd_a};
    rb_next = {1'b0, bus.cmd_b};
    s_next  = 1'b0;
    case (bus.cmd_op)
      OP_ADD: s_next = 1'b0;
      OP_SUB: s_next = 1'b1;
      OP_CMP: s_next = 1'b1;
      OP_INC: begin
        rb_next = {{BITS{1'b0}}, 1'b1};
        s_next  = 1'b0;
      end
      default: s_next = 1'b0;
    endcase
  end

  // Next-state and status decode for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_next    = state_reg;
    capture       = 1'b0;
    rsp_valid_int = 1'b0;
    busy_int      = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        busy_int = 1'b0;
        if (accept) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU has had a full cycle to settle on the registered operands.
        capture    = 1'b1;
        state_next = (op_reg == OP_CMP) ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_int = 1'b1;
        if (bus.rsp_ready) begin
          state_next = accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand/op registers: loaded only on accept so the ALU inputs stay put
  // while the sequencer is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_reg <= '0;
      rb_reg <= '0;
      s_reg  <= 1'b0;
      op_reg <= OP_ADD;
    end else if (accept) begin
      ra_reg <= ra_next;
      rb_reg <= rb_next;
      s_reg  <= s_next;
      op_reg <= bus.cmd_op;
    end
  end

  // Response fields: captured from the ALU at the end of EXEC, except for CMP
  // which leaves the previous response untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_reg  <= '0;
      rsp_carry_reg <= 1'b0;
      rsp_zero_reg  <= 1'b0;
    end else if (capture && (op_reg != OP_CMP)) begin
      rsp_data_reg  <= alu_out[BITS-1:0];
      rsp_carry_reg <= alu_carry;
      rsp_zero_reg  <= alu_zero;
    end
  end

  // Sticky flags and completed-op counter: every op, CMP included, updates
  // them on completion. The counter wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c_reg   <= 1'b0;
      flag_z_reg   <= 1'b0;
      op_count_reg <= 8'd0;
    end else if (capture) begin
      flag_c_reg   <= alu_carry;
      flag_z_reg   <= alu_zero;
      op_count_reg <= op_count_reg + 8'd1;
    end
  end

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_carry = rsp_carry_reg;
  assign bus.rsp_zero  = rsp_zero_reg;

  assign alu_ra   = ra_reg;
  assign alu_rb   = rb_reg;
  assign alu_s    = s_reg;
  assign flag_c   = flag_c_reg;
  assign flag_z   = flag_z_reg;
  assign busy     = busy_int;
  assign op_count = op_count_reg;

endmodule
